cv32e40x_xif_aes_queue: RTL and testbench



---
 rtl/cv32e40x_xif_aes_queue.sv | 230 +++++++++++++++++++++++
 tb/tb_cv32e40x_xif_aes_queue.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_xif_aes_queue.sv
// XIF coprocessor for Zkn aes32{e,d}s{,m}i: in-order instruction buffer with
// per-ID commit/kill tracking feeding a stallable saes32 pipeline.
module cv32e40x_xif_aes_queue #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFR_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter int PIPE_STAGES = 1,
    parameter int DEC_EN      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [31:0]            issue_instr,
    input  logic [X_ID_WIDTH-1:0]  issue_id,
    input  logic [X_RFR_WIDTH-1:0] issue_rs0,
    input  logic [X_RFR_WIDTH-1:0] issue_rs1,
    input  logic [1:0]             issue_rs_valid,
    output logic                   issue_accept,
    output logic                   issue_writeback,
    input  logic                   commit_valid,
    input  logic [X_ID_WIDTH-1:0]  commit_id,
    input  logic                   commit_kill,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [X_ID_WIDTH-1:0]  result_id,
    output logic [X_RFR_WIDTH-1:0] result_data,
    output logic [4:0]             result_rd,
    output logic                   result_we
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_WAIT,
        ST_COMMITTED,
        ST_KILLED
    } ent_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] saes32(input logic [31:0] rs1, input logic [31:0] rs2,
                                           input logic [1:0] bs, input logic dec,
                                           input logic mix);
        logic [7:0]  si;
        logic [7:0]  so;
        logic [31:0] mixed;
        logic [31:0] rot;
        case (bs)
            2'd0:    si = rs2[7:0];
            2'd1:    si = rs2[15:8];
            2'd2:    si = rs2[23:16];
            default: si = rs2[31:24];
        endcase
        so = dec ? sbox_inv(si) : sbox_fwd(si);
        if (!mix)
            mixed = {24'h000000, so};
        else if (!dec)
            mixed = {gf_mul(so, 8'h03), so, so, gf_mul(so, 8'h02)};
        else
            mixed = {gf_mul(so, 8'h0b), gf_mul(so, 8'h0d), gf_mul(so, 8'h09), gf_mul(so, 8'h0e)};
        case (bs)
            2'd0:    rot = mixed;
            2'd1:    rot = {mixed[23:0], mixed[31:24]};
            2'd2:    rot = {mixed[15:0], mixed[31:16]};
            default: rot = {mixed[7:0], mixed[31:8]};
        endcase
        return rs1 ^ rot;
    endfunction

    ent_state_t             ent_st     [DEPTH];
    ent_state_t             ent_st_nxt [DEPTH];
    logic [X_ID_WIDTH-1:0]  ent_id     [DEPTH];
    logic [X_RFR_WIDTH-1:0] ent_rs0    [DEPTH];
    logic [X_RFR_WIDTH-1:0] ent_rs1    [DEPTH];
    logic [4:0]             ent_rd     [DEPTH];
    logic [1:0]             ent_bs     [DEPTH];
    logic                   ent_dec    [DEPTH];
    logic                   ent_mix    [DEPTH];

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] occ;

    logic                   st_valid [PIPE_STAGES+1];
    logic [X_ID_WIDTH-1:0]  st_id    [PIPE_STAGES+1];
    logic [X_RFR_WIDTH-1:0] st_data  [PIPE_STAGES+1];
    logic [4:0]             st_rd    [PIPE_STAGES+1];

    logic [4:0]             funct5;
    logic                   op_ok;
    logic                   dec_ok;
    logic                   push;
    logic                   pop;
    logic                   dispatch;
    logic                   advance;
    ent_state_t             head_st;
    logic [X_RFR_WIDTH-1:0] disp_data;
    logic                   unused_instr;

    assign funct5 = issue_instr[29:25];
    assign op_ok  = (issue_instr[6:0] == 7'b0110011) && (issue_instr[14:12] == 3'b000)
                  && funct5[4] && !funct5[3] && funct5[0] && (!funct5[2] || (DEC_EN != 0));
    assign dec_ok = op_ok && (issue_rs_valid == 2'b11);
    assign unused_instr = ^issue_instr[24:15];

    assign issue_ready     = !rst && (occ < CNT_W'(DEPTH));
    assign issue_accept    = issue_valid && dec_ok;
    assign issue_writeback = issue_accept;
    assign push            = issue_valid && issue_ready && dec_ok;

    // The result register is the last stage; any held result freezes the whole chain.
    assign advance   = !st_valid[PIPE_STAGES] || result_ready;
    assign head_st   = ent_st[head_ptr];
    assign dispatch  = (head_st == ST_COMMITTED) && advance;
    assign pop       = dispatch || (head_st == ST_KILLED);
    assign disp_data = saes32(ent_rs0[head_ptr], ent_rs1[head_ptr], ent_bs[head_ptr],
                              ent_dec[head_ptr], ent_mix[head_ptr]);

    // A commit also hits the entry being written this cycle, matched on the incoming ID.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_st_nxt[i] = ent_st[i];
            if (pop && head_ptr == PTR_W'(i))
                ent_st_nxt[i] = ST_EMPTY;
            if (push && tail_ptr == PTR_W'(i))
                ent_st_nxt[i] = ST_WAIT;
            if (commit_valid && ent_st_nxt[i] == ST_WAIT
                && commit_id == ((push && tail_ptr == PTR_W'(i)) ? issue_id : ent_id[i]))
                ent_st_nxt[i] = commit_kill ? ST_KILLED : ST_COMMITTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                ent_st[i] <= ST_EMPTY;
            head_ptr <= '0;
            tail_ptr <= '0;
            occ      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                ent_st[i] <= ent_st_nxt[i];
            if (push) begin
                ent_id[tail_ptr]  <= issue_id;
                ent_rs0[tail_ptr] <= issue_rs0;
                ent_rs1[tail_ptr] <= issue_rs1;
                ent_rd[tail_ptr]  <= issue_instr[11:7];
                ent_bs[tail_ptr]  <= issue_instr[31:30];
                ent_dec[tail_ptr] <= issue_instr[27];
                ent_mix[tail_ptr] <= issue_instr[26];
                tail_ptr          <= tail_ptr + 1'b1;
            end
            if (pop)
                head_ptr <= head_ptr + 1'b1;
            occ <= occ + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= PIPE_STAGES; k++) begin
                st_valid[k] <= 1'b0;
                st_id[k]    <= '0;
                st_data[k]  <= '0;
                st_rd[k]    <= '0;
            end
        end else if (advance) begin
            st_valid[0] <= dispatch;
            st_id[0]    <= ent_id[head_ptr];
            st_data[0]  <= disp_data;
            st_rd[0]    <= ent_rd[head_ptr];
            for (int k = 1; k <= PIPE_STAGES; k++) begin
                st_valid[k] <= st_valid[k-1];
                st_id[k]    <= st_id[k-1];
                st_data[k]  <= st_data[k-1];
                st_rd[k]    <= st_rd[k-1];
            end
        end
    end

    assign result_valid = st_valid[PIPE_STAGES];
    assign result_id    = st_id[PIPE_STAGES];
    assign result_data  = st_data[PIPE_STAGES];
    assign result_rd    = st_rd[PIPE_STAGES];
    assign result_we    = st_valid[PIPE_STAGES];

endmodule

// File: tb/tb_cv32e40x_xif_aes_queue.sv
// Directed bench for cv32e40x_xif_aes_queue: a DEC_EN=1 instance for the main
// flow and a DEC_EN=0 instance for decrypt rejection.
module tb_cv32e40x_xif_aes_queue;

    localparam logic [31:0] ESI  = 32'h22000033;
    localparam logic [31:0] ESMI = 32'h26000033;
    localparam logic [31:0] DSI  = 32'h2A000033;
    localparam logic [31:0] DSMI = 32'h2E000033;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        nd_issue_valid;
    logic [31:0] issue_instr;
    logic [3:0]  issue_id;
    logic [31:0] issue_rs0;
    logic [31:0] issue_rs1;
    logic [1:0]  issue_rs_valid;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic        result_ready;

    logic        issue_ready, issue_accept, issue_writeback;
    logic        result_valid, result_we;
    logic [3:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;

    logic        nd_issue_ready, nd_issue_accept, nd_issue_writeback;
    logic        nd_result_valid, nd_result_we;
    logic [3:0]  nd_result_id;
    logic [31:0] nd_result_data;
    logic [4:0]  nd_result_rd;

    int total = 0;
    int bad   = 0;
    int nd_res_cnt = 0;
    logic [3:0]  res_id_q   [$];
    logic [31:0] res_data_q [$];
    logic [4:0]  res_rd_q   [$];

    cv32e40x_xif_aes_queue #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32), .DEPTH(4),
                             .PIPE_STAGES(1), .DEC_EN(1)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
        .issue_id(issue_id), .issue_rs0(issue_rs0), .issue_rs1(issue_rs1),
        .issue_rs_valid(issue_rs_valid), .issue_accept(issue_accept),
        .issue_writeback(issue_writeback),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
        .result_data(result_data), .result_rd(result_rd), .result_we(result_we)
    );

    cv32e40x_xif_aes_queue #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32), .DEPTH(4),
                             .PIPE_STAGES(1), .DEC_EN(0)) dut_nd (
        .clk(clk), .rst(rst),
        .issue_valid(nd_issue_valid), .issue_ready(nd_issue_ready), .issue_instr(issue_instr),
        .issue_id(issue_id), .issue_rs0(issue_rs0), .issue_rs1(issue_rs1),
        .issue_rs_valid(issue_rs_valid), .issue_accept(nd_issue_accept),
        .issue_writeback(nd_issue_writeback),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .result_valid(nd_result_valid), .result_ready(result_ready), .result_id(nd_result_id),
        .result_data(nd_result_data), .result_rd(nd_result_rd), .result_we(nd_result_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result handshakes are logged mid-cycle so the main sequence can check order later.
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            res_id_q.push_back(result_id);
            res_data_q.push_back(result_data);
            res_rd_q.push_back(result_rd);
        end
        if (!rst && nd_result_valid && result_ready)
            nd_res_cnt++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit to_nd, input logic [3:0] id, input logic [31:0] instr,
                                 input logic [31:0] rs0, input logic [31:0] rs1,
                                 input logic [1:0] rsv, input logic exp_acc, input string tag);
        issue_id       = id;
        issue_instr    = instr;
        issue_rs0      = rs0;
        issue_rs1      = rs1;
        issue_rs_valid = rsv;
        if (to_nd) nd_issue_valid = 1'b1;
        else       issue_valid    = 1'b1;
        #1;
        if (to_nd) begin
            checkOutput({tag, " ready"}, 64'(nd_issue_ready), 64'd1);
            checkOutput({tag, " accept"}, 64'(nd_issue_accept), 64'(exp_acc));
            checkOutput({tag, " writeback"}, 64'(nd_issue_writeback), 64'(exp_acc));
        end else begin
            checkOutput({tag, " ready"}, 64'(issue_ready), 64'd1);
            checkOutput({tag, " accept"}, 64'(issue_accept), 64'(exp_acc));
        end
        cyc();
        issue_valid    = 1'b0;
        nd_issue_valid = 1'b0;
        issue_rs_valid = 2'b11;
    endtask

    task automatic commitId(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
        cyc();
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    task automatic waitResults(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (res_id_q.size() < n && c < budget) begin
            cyc();
            c++;
        end
        checkOutput({tag, " result count"}, 64'(res_id_q.size()), 64'(n));
    endtask

    task automatic popCheck(input string tag, input logic [3:0] eid, input logic [31:0] edata,
                            input logic [4:0] erd);
        checkOutput({tag, " present"}, 64'(res_id_q.size() != 0), 64'd1);
        if (res_id_q.size() != 0) begin
            checkOutput({tag, " id"}, 64'(res_id_q.pop_front()), 64'(eid));
            checkOutput({tag, " data"}, 64'(res_data_q.pop_front()), 64'(edata));
            checkOutput({tag, " rd"}, 64'(res_rd_q.pop_front()), 64'(erd));
        end
    endtask

    task automatic clearLog();
        res_id_q.delete();
        res_data_q.delete();
        res_rd_q.delete();
    endtask

    task automatic runOp(input logic [3:0] id, input logic [31:0] instr, input logic [31:0] rs0,
                         input logic [31:0] rs1, input logic [31:0] edata,
                         input logic [4:0] erd, input string tag);
        clearLog();
        applyStimulus(1'b0, id, instr, rs0, rs1, 2'b11, 1'b1, tag);
        commitId(id, 1'b0);
        waitResults(1, 10, tag);
        popCheck(tag, id, edata, erd);
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0;
        nd_issue_valid = 1'b0;
        issue_instr = 32'h0;
        issue_id = 4'h0;
        issue_rs0 = 32'h0;
        issue_rs1 = 32'h0;
        issue_rs_valid = 2'b11;
        commit_valid = 1'b0;
        commit_id = 4'h0;
        commit_kill = 1'b0;
        result_ready = 1'b1;
        repeat (3) cyc();
        checkOutput("reset ready", 64'(issue_ready), 64'd0);
        checkOutput("reset valid", 64'(result_valid), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post reset ready", 64'(issue_ready), 64'd1);
        checkOutput("post reset valid", 64'(result_valid), 64'd0);
        checkOutput("post reset id", 64'(result_id), 64'd0);
        checkOutput("post reset data", 64'(result_data), 64'd0);
        checkOutput("post reset rd", 64'(result_rd), 64'd0);
        checkOutput("post reset we", 64'(result_we), 64'd0);

        // Latency: commit the cycle after issue, result_valid two cycles after dispatch.
        clearLog();
        applyStimulus(1'b0, 4'd3, ESI, 32'h0, 32'h0, 2'b11, 1'b1, "lat issue");
        commitId(4'd3, 1'b0);
        checkOutput("lat dispatch cycle valid", 64'(result_valid), 64'd0);
        cyc();
        checkOutput("lat stage cycle valid", 64'(result_valid), 64'd0);
        cyc();
        checkOutput("lat valid", 64'(result_valid), 64'd1);
        checkOutput("lat id", 64'(result_id), 64'd3);
        checkOutput("lat data", 64'(result_data), 64'h00000063);
        checkOutput("lat rd", 64'(result_rd), 64'd0);
        checkOutput("lat we", 64'(result_we), 64'd1);
        cyc();
        checkOutput("lat drained", 64'(result_valid), 64'd0);
        popCheck("lat log", 4'd3, 32'h00000063, 5'd0);

        runOp(4'd1, ESMI, 32'h0, 32'h0, 32'hA56363C6, 5'd0, "esmi");
        runOp(4'd2, DSI, 32'h0, 32'h0, 32'h00000052, 5'd0, "dsi");
        runOp(4'd4, DSMI, 32'h0, 32'h0, 32'h50A7F451, 5'd0, "dsmi");
        runOp(4'd5, 32'h620002B3, 32'h11111111, 32'h00000100, 32'h11116D11, 5'd5, "esi bs1");
        runOp(4'd6, 32'hE6000FB3, 32'h0, 32'h01000000, 32'hF8847C7C, 5'd31, "esmi bs3");

        // Rejected requests store nothing, so a later commit of their ID is a no-op.
        clearLog();
        applyStimulus(1'b0, 4'd7, ESI, 32'h0, 32'h0, 2'b01, 1'b0, "rej rsvalid");
        applyStimulus(1'b0, 4'd7, 32'h22000013, 32'h0, 32'h0, 2'b11, 1'b0, "rej opcode");
        applyStimulus(1'b0, 4'd7, 32'h22001033, 32'h0, 32'h0, 2'b11, 1'b0, "rej funct3");
        applyStimulus(1'b0, 4'd7, 32'h20000033, 32'h0, 32'h0, 2'b11, 1'b0, "rej funct5");
        commitId(4'd7, 1'b0);
        repeat (6) cyc();
        checkOutput("rej no result", 64'(res_id_q.size()), 64'd0);

        // Commit or kill arriving in the same cycle as the issue of that ID.
        clearLog();
        commit_valid = 1'b1; commit_id = 4'd6; commit_kill = 1'b0;
        applyStimulus(1'b0, 4'd6, ESI, 32'hCAFE0000, 32'h0, 2'b11, 1'b1, "same-cycle commit");
        commit_valid = 1'b1; commit_id = 4'd7; commit_kill = 1'b1;
        applyStimulus(1'b0, 4'd7, ESI, 32'h0, 32'h0, 2'b11, 1'b1, "same-cycle kill");
        commit_valid = 1'b0; commit_kill = 1'b0;
        waitResults(1, 10, "same-cycle");
        popCheck("same-cycle commit", 4'd6, 32'hCAFE0063, 5'd0);
        repeat (5) cyc();
        checkOutput("same-cycle kill dropped", 64'(res_id_q.size()), 64'd0);

        applyStimulus(1'b1, 4'd12, DSI, 32'h0, 32'h0, 2'b11, 1'b0, "nodec dsi");
        applyStimulus(1'b1, 4'd13, DSMI, 32'h0, 32'h0, 2'b11, 1'b0, "nodec dsmi");
        applyStimulus(1'b1, 4'd14, ESI, 32'h0, 32'h0, 2'b11, 1'b1, "nodec esi");
        commitId(4'd12, 1'b0);
        commitId(4'd13, 1'b0);
        commitId(4'd14, 1'b0);
        repeat (8) cyc();
        checkOutput("nodec result count", 64'(nd_res_cnt), 64'd1);

        clearLog();
        applyStimulus(1'b0, 4'd1, ESI, 32'h1, 32'h0, 2'b11, 1'b1, "kill issue1");
        applyStimulus(1'b0, 4'd2, ESI, 32'h2, 32'h0, 2'b11, 1'b1, "kill issue2");
        applyStimulus(1'b0, 4'd3, ESI, 32'h3, 32'h0, 2'b11, 1'b1, "kill issue3");
        commitId(4'd2, 1'b1);
        commitId(4'd1, 1'b0);
        commitId(4'd3, 1'b0);
        waitResults(2, 12, "kill");
        popCheck("kill first", 4'd1, 32'h00000062, 5'd0);
        popCheck("kill second", 4'd3, 32'h00000060, 5'd0);
        repeat (5) cyc();
        checkOutput("kill exactly two", 64'(res_id_q.size()), 64'd0);

        clearLog();
        applyStimulus(1'b0, 4'd8, ESI, 32'h08000000, 32'h0, 2'b11, 1'b1, "full issue8");
        applyStimulus(1'b0, 4'd9, ESI, 32'h0, 32'h0, 2'b11, 1'b1, "full issue9");
        applyStimulus(1'b0, 4'd10, ESI, 32'h0, 32'h0, 2'b11, 1'b1, "full issue10");
        applyStimulus(1'b0, 4'd11, ESI, 32'h0, 32'h0, 2'b11, 1'b1, "full issue11");
        checkOutput("full ready low", 64'(issue_ready), 64'd0);
        commitId(4'd8, 1'b0);
        checkOutput("full ready during pop", 64'(issue_ready), 64'd0);
        cyc();
        checkOutput("full ready after pop", 64'(issue_ready), 64'd1);
        commitId(4'd9, 1'b1);
        commitId(4'd10, 1'b1);
        commitId(4'd11, 1'b1);
        waitResults(1, 10, "full");
        popCheck("full head", 4'd8, 32'h08000063, 5'd0);
        repeat (4) cyc();
        checkOutput("full kills dropped", 64'(res_id_q.size()), 64'd0);

        // Backpressure: the held result must not move while the core refuses it.
        clearLog();
        result_ready = 1'b0;
        applyStimulus(1'b0, 4'd1, ESI, 32'h00001000, 32'h0, 2'b11, 1'b1, "bp issue1");
        applyStimulus(1'b0, 4'd2, ESI, 32'h00002000, 32'h0, 2'b11, 1'b1, "bp issue2");
        applyStimulus(1'b0, 4'd3, ESI, 32'h00003000, 32'h0, 2'b11, 1'b1, "bp issue3");
        commitId(4'd1, 1'b0);
        commitId(4'd2, 1'b0);
        commitId(4'd3, 1'b0);
        for (int c = 0; c < 10 && !result_valid; c++) cyc();
        checkOutput("bp valid", 64'(result_valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            cyc();
            checkOutput("bp held valid", 64'(result_valid), 64'd1);
            checkOutput("bp held id", 64'(result_id), 64'd1);
            checkOutput("bp held data", 64'(result_data), 64'h00001063);
        end
        result_ready = 1'b1;
        #1;
        checkOutput("bp release valid1", 64'(result_valid), 64'd1);
        cyc();
        checkOutput("bp release valid2", 64'(result_valid), 64'd1);
        cyc();
        checkOutput("bp release valid3", 64'(result_valid), 64'd1);
        cyc();
        checkOutput("bp release empty", 64'(result_valid), 64'd0);
        popCheck("bp r1", 4'd1, 32'h00001063, 5'd0);
        popCheck("bp r2", 4'd2, 32'h00002063, 5'd0);
        popCheck("bp r3", 4'd3, 32'h00003063, 5'd0);

        clearLog();
        applyStimulus(1'b0, 4'd1, ESI, 32'h1, 32'h0, 2'b11, 1'b1, "rst issue1");
        applyStimulus(1'b0, 4'd2, ESI, 32'h2, 32'h0, 2'b11, 1'b1, "rst issue2");
        applyStimulus(1'b0, 4'd3, ESI, 32'h3, 32'h0, 2'b11, 1'b1, "rst issue3");
        commitId(4'd1, 1'b0);
        cyc();
        rst = 1'b1;
        #1;
        checkOutput("rst ready low", 64'(issue_ready), 64'd0);
        cyc();
        checkOutput("rst valid cleared", 64'(result_valid), 64'd0);
        checkOutput("rst data cleared", 64'(result_data), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst ready back", 64'(issue_ready), 64'd1);
        commitId(4'd2, 1'b0);
        commitId(4'd3, 1'b0);
        commitId(4'd1, 1'b0);
        repeat (8) cyc();
        checkOutput("rst no result", 64'(res_id_q.size()), 64'd0);
        checkOutput("rst idle valid", 64'(result_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
